touch_packet_rx: RTL and testbench

- Receives the resistive-touch controller's 8N1 serial stream on the touch UART RXD pin and decodes 5-byte touch reports into X/Y/pen samples.
- Presents decoded samples on a valid/ready interface to the Avalon-MM touch register slave, which the Nios reads before forwarding strokes over WiFi and drawing to VGA.
- Replaces per-byte software polling of the touch UART.

---
 rtl/touch_pkg.sv | 32 +++
 rtl/touch_uart_rx.sv | 102 ++++++++++
 rtl/touch_packet_rx.sv | 179 +++++++++++++++++
 tb/tb_touch_packet_rx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/touch_pkg.sv
// rtl/touch_pkg.sv - shared types and constants for the touch report receiver
package touch_pkg;

  typedef enum logic [2:0] {
    S_HDR,
    S_X0,
    S_X1,
    S_Y0,
    S_Y1
  } pkt_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  localparam logic [6:0] TOUCH_HDR_MASK = 7'b1000000;
  localparam int TOUCH_PKT_BYTES = 5;

  // Pixel scaling: X*5>>5 maps 0..4095 to 0..639, Y*15>>7 maps to 0..479
  localparam int SCALE_X_MUL   = 5;
  localparam int SCALE_X_SHIFT = 5;
  localparam int SCALE_Y_MUL   = 15;
  localparam int SCALE_Y_SHIFT = 7;

  function automatic logic is_header(input logic [7:0] b);
    return b[7:1] == TOUCH_HDR_MASK;
  endfunction

endpackage

// File: rtl/touch_uart_rx.sv
// rtl/touch_uart_rx.sv - 8N1 receiver with input synchroniser for the touch UART
module touch_uart_rx
  import touch_pkg::*;
#(
  parameter int DIV = 50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rxd,
  output logic       byte_stb,
  output logic [7:0] byte_data,
  output logic       stop_err
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF_CNT = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DIV - 1);

  rx_state_t     rx_state;
  rx_state_t     rx_next;
  logic          rxd_meta;
  logic          rxd_s;
  logic          rxd_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          fall;
  logic          cnt_done;

  // Preset high so reset release on an idle line never looks like a start bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_s    <= rxd_meta;
      rxd_prev <= rxd_s;
    end
  end

  assign fall     = rxd_prev & ~rxd_s;
  assign cnt_done = (cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= R_IDLE;
    end else begin
      rx_state <= rx_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:  if (fall) rx_next = R_START;
      R_START: if (cnt_done) rx_next = rxd_s ? R_IDLE : R_DATA;
      R_DATA:  if (cnt_done && bit_idx == 3'd7) rx_next = R_STOP;
      R_STOP:  if (cnt_done) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  always_comb begin
    byte_stb = 1'b0;
    stop_err = 1'b0;
    if (rx_state == R_STOP && cnt_done) begin
      byte_stb = rxd_s;
      stop_err = ~rxd_s;
    end
  end

  // Idle keeps the half-bit count preloaded so the start bit is checked mid-bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (rx_state)
        R_IDLE: begin
          cnt     <= HALF_CNT;
          bit_idx <= '0;
        end
        R_DATA: begin
          if (cnt_done) begin
            shreg   <= {rxd_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            cnt     <= FULL_CNT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: cnt <= cnt_done ? FULL_CNT : cnt - 1'b1;
      endcase
    end
  end

  assign byte_data = shreg;

endmodule

// File: rtl/touch_packet_rx.sv
// rtl/touch_packet_rx.sv - decodes 5-byte touch reports into X/Y/pen samples
// Optional pixel scaling of X/Y is built when TOUCH_PIXEL_SCALE_EN is defined.
module touch_packet_rx
  import touch_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 9600,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        uart_rxd,
  output logic [11:0] out_x,
  output logic [11:0] out_y,
  output logic        out_pen,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic        frame_err,
  input  logic        clr_status
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int TW  = $clog2(DIV);
  localparam int BW  = $clog2(TIMEOUT_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [BW-1:0] BITS_MAX  = BW'(TIMEOUT_BITS);

  logic        byte_stb;
  logic [7:0]  byte_data;
  logic        stop_err;

  pkt_state_t  pkt_state;
  pkt_state_t  pkt_next;
  logic        hdr_load;
  logic        data_byte;
  logic        complete;
  logic        timeout;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] idle_bits;

  logic [11:0] x_acc;
  logic [6:0]  y_lo;
  logic        pen_acc;
  logic [11:0] new_x;
  logic [11:0] new_y;
  logic [11:0] pix_x;
  logic [11:0] pix_y;

  touch_uart_rx #(
    .DIV(DIV)
  ) u_uart_rx (
    .clk      (clk),
    .reset_n  (reset_n),
    .uart_rxd (uart_rxd),
    .byte_stb (byte_stb),
    .byte_data(byte_data),
    .stop_err (stop_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_state <= S_HDR;
    end else begin
      pkt_state <= pkt_next;
    end
  end

  // Any byte with bit7 set resynchronises, whatever state we are in
  always_comb begin
    pkt_next = pkt_state;
    if (stop_err) begin
      pkt_next = S_HDR;
    end else if (byte_stb) begin
      if (pkt_state == S_HDR || byte_data[7]) begin
        pkt_next = is_header(byte_data) ? S_X0 : S_HDR;
      end else begin
        case (pkt_state)
          S_X0:    pkt_next = S_X1;
          S_X1:    pkt_next = S_Y0;
          S_Y0:    pkt_next = S_Y1;
          default: pkt_next = S_HDR;
        endcase
      end
    end else if (timeout) begin
      pkt_next = S_HDR;
    end
  end

  always_comb begin
    hdr_load  = byte_stb && is_header(byte_data);
    data_byte = byte_stb && !byte_data[7] && (pkt_state != S_HDR);
    complete  = data_byte && (pkt_state == S_Y1);
  end

  // Bit-period ticks since the last byte; idle in S_HDR so it never fires there
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt  <= '0;
      idle_bits <= '0;
    end else if (byte_stb || pkt_state == S_HDR) begin
      tick_cnt  <= '0;
      idle_bits <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      if (!timeout) idle_bits <= idle_bits + 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign timeout = (idle_bits == BITS_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_acc   <= '0;
      y_lo    <= '0;
      pen_acc <= 1'b0;
    end else if (hdr_load) begin
      pen_acc <= byte_data[0];
    end else if (data_byte) begin
      case (pkt_state)
        S_X0:    x_acc[6:0]  <= byte_data[6:0];
        S_X1:    x_acc[11:7] <= byte_data[4:0];
        S_Y0:    y_lo        <= byte_data[6:0];
        default: ;
      endcase
    end
  end

  assign new_x = x_acc;
  assign new_y = {byte_data[4:0], y_lo};

`ifdef TOUCH_PIXEL_SCALE_EN
  logic [14:0] x_prod;
  logic [15:0] y_prod;
  assign x_prod = 15'(new_x) * 15'(SCALE_X_MUL);
  assign y_prod = 16'(new_y) * 16'(SCALE_Y_MUL);
  assign pix_x  = 12'(x_prod >> SCALE_X_SHIFT);
  assign pix_y  = 12'(y_prod >> SCALE_Y_SHIFT);
`else
  assign pix_x = new_x;
  assign pix_y = new_y;
`endif

  // A completion always wins over acceptance; overwrite only counts as loss if unread
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_x     <= '0;
      out_y     <= '0;
      out_pen   <= 1'b0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (complete) begin
        out_x     <= pix_x;
        out_y     <= pix_y;
        out_pen   <= pen_acc;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (complete && out_valid && !out_ready) begin
        overflow <= 1'b1;
      end else if (clr_status) begin
        overflow <= 1'b0;
      end

      if (stop_err) begin
        frame_err <= 1'b1;
      end else if (clr_status) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_touch_packet_rx.sv
// tb/tb_touch_packet_rx.sv - self-checking bench for touch_packet_rx
module tb_touch_packet_rx;

  localparam int CLK_HZ       = 50_000_000;
  localparam int BAUD         = 1_000_000;
  localparam int DIV          = CLK_HZ / BAUD;
  localparam int TIMEOUT_BITS = 40;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        uart_rxd = 1'b1;
  logic        out_ready = 1'b0;
  logic        clr_status = 1'b0;
  logic [11:0] out_x;
  logic [11:0] out_y;
  logic        out_pen;
  logic        out_valid;
  logic        overflow;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  // Reference model: packet position, captured bytes and expected outputs
  int          m_phase;
  int          m_pkt[5];
  logic        m_pen;
  logic        e_valid;
  logic        e_pen;
  logic        e_ovf;
  logic        e_ferr;
  logic [11:0] e_x;
  logic [11:0] e_y;

  touch_packet_rx #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .uart_rxd  (uart_rxd),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_pen   (out_pen),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clr_status(clr_status)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/valid"}, 12'(out_valid), 12'(e_valid));
    chk({tag, "/x"}, out_x, e_x);
    chk({tag, "/y"}, out_y, e_y);
    chk({tag, "/pen"}, 12'(out_pen), 12'(e_pen));
    chk({tag, "/overflow"}, 12'(overflow), 12'(e_ovf));
    chk({tag, "/frame_err"}, 12'(frame_err), 12'(e_ferr));
  endtask

  function automatic logic [11:0] scale_x(input int x);
`ifdef TOUCH_PIXEL_SCALE_EN
    return 12'((x * 5) / 32);
`else
    return 12'(x);
`endif
  endfunction

  function automatic logic [11:0] scale_y(input int y);
`ifdef TOUCH_PIXEL_SCALE_EN
    return 12'((y * 15) / 128);
`else
    return 12'(y);
`endif
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_pen   = 1'b0;
    e_valid = 1'b0;
    e_pen   = 1'b0;
    e_ovf   = 1'b0;
    e_ferr  = 1'b0;
    e_x     = '0;
    e_y     = '0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic stop, input logic rdy);
    int x;
    int y;
    if (!stop) begin
      e_ferr  = 1'b1;
      m_phase = 0;
      return;
    end
    if (m_phase == 0 || b[7]) begin
      if (b[7:1] == 7'h40) begin
        m_pen   = b[0];
        m_phase = 1;
      end else begin
        m_phase = 0;
      end
    end else begin
      m_pkt[m_phase] = int'(b);
      m_phase++;
      if (m_phase == 5) begin
        x = (m_pkt[2] % 32) * 128 + (m_pkt[1] % 128);
        y = (m_pkt[4] % 32) * 128 + (m_pkt[3] % 128);
        if (e_valid && !rdy) e_ovf = 1'b1;
        e_valid = 1'b1;
        e_x     = scale_x(x);
        e_y     = scale_y(y);
        e_pen   = m_pen;
        m_phase = 0;
      end
    end
  endtask

  // mode 1: check out_valid around the stop sample; mode 2: out_ready high in the completion cycle
  task automatic send_byte(input logic [7:0] b, input logic stop, input int mode);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = fr[i];
      if (i == 9 && mode != 0) begin
        repeat (27) @(posedge clk);
        #1;
        if (mode == 1) chk("latency_pre", 12'(out_valid), 12'd0);
        if (mode == 2) out_ready = 1'b1;
        @(posedge clk);
        #1;
        if (mode == 1) chk("latency_post", 12'(out_valid), 12'd1);
        if (mode == 2) out_ready = 1'b0;
        repeat (DIV - 28) @(posedge clk);
        #1;
      end else begin
        repeat (DIV) @(posedge clk);
        #1;
      end
    end
    uart_rxd = 1'b1;
    if (!stop) begin
      repeat (DIV) @(posedge clk);
      #1;
    end
    model_byte(b, stop, mode == 2);
  endtask

  task automatic send5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4, input int last_mode);
    send_byte(b0, 1'b1, 0);
    send_byte(b1, 1'b1, 0);
    send_byte(b2, 1'b1, 0);
    send_byte(b3, 1'b1, 0);
    send_byte(b4, 1'b1, last_mode);
  endtask

  task automatic idle_bits(input int n);
    repeat (n * DIV) @(posedge clk);
    #1;
    if (n >= 35) m_phase = 0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    e_valid = 1'b0;
  endtask

  task automatic clear_status();
    clr_status = 1'b1;
    @(posedge clk);
    #1;
    clr_status = 1'b0;
    e_ovf  = 1'b0;
    e_ferr = 1'b0;
  endtask

  initial begin
    logic [11:0] rx;
    logic [11:0] ry;
    logic        rpen;
    int          nj;

    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check_all("reset");
    reset_n = 1'b1;
    idle_bits(2);

    // Nominal packet, latency and hold
    send5(8'h81, 8'h22, 8'h1F, 8'h0F, 8'h0A, 1);
    check_all("basic");
`ifndef TOUCH_PIXEL_SCALE_EN
    chk("basic_x_const", out_x, 12'hFA2);
    chk("basic_y_const", out_y, 12'h50F);
`endif
    repeat (100) @(posedge clk);
    #1;
    check_all("hold");
    accept();
    check_all("accepted");

    // Framing error mid-packet, then a clean all-zero packet
    send_byte(8'h81, 1'b1, 0);
    send_byte(8'h22, 1'b1, 0);
    send_byte(8'h1F, 1'b0, 0);
    send_byte(8'h0F, 1'b1, 0);
    send_byte(8'h0A, 1'b1, 0);
    check_all("frame_err");
    send5(8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    check_all("zero_pkt");
    accept();
    clear_status();
    check_all("clr_status");

    // Overwrite while unread, then completion coinciding with acceptance
    send5(8'h81, 8'h11, 8'h02, 8'h33, 8'h04, 0);
    send5(8'h80, 8'h55, 8'h06, 8'h77, 8'h08, 0);
    check_all("overflow");
    clear_status();
    check_all("overflow_clr");
    send5(8'h81, 8'h01, 8'h1E, 8'h02, 8'h1D, 2);
    check_all("accept_complete");
    accept();
    check_all("accept_after");

    // Inter-byte timeout discards a partial packet
    send_byte(8'h81, 1'b1, 0);
    send_byte(8'h22, 1'b1, 0);
    send_byte(8'h1F, 1'b1, 0);
    idle_bits(45);
    send_byte(8'h0F, 1'b1, 0);
    send_byte(8'h0A, 1'b1, 0);
    check_all("timeout_drop");
    send_byte(8'h81, 1'b1, 0);
    send_byte(8'h05, 1'b1, 0);
    idle_bits(45);
    send5(8'h81, 8'h7F, 8'h1F, 8'h7F, 8'h1F, 0);
    check_all("timeout_max");
    accept();
    send_byte(8'h81, 1'b1, 0);
    send_byte(8'h7F, 1'b1, 0);
    send5(8'h80, 8'h7F, 8'h1F, 8'h7F, 8'h1F, 0);
    check_all("resync_hdr");
    accept();

    // Short low glitch in a packet gap must not produce a byte
    send_byte(8'h81, 1'b1, 0);
    send_byte(8'h22, 1'b1, 0);
    send_byte(8'h1F, 1'b1, 0);
    send_byte(8'h0F, 1'b1, 0);
    idle_bits(2);
    uart_rxd = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    uart_rxd = 1'b1;
    idle_bits(3);
    send_byte(8'h0A, 1'b1, 0);
    check_all("glitch");

    // Reset in the middle of a byte
    uart_rxd = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    reset_n  = 1'b0;
    uart_rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_all("reset_mid");
    reset_n = 1'b1;
    idle_bits(15);
    send5(8'h81, 8'h00, 8'h10, 8'h00, 8'h00, 0);
    check_all("after_reset");
    accept();

    // Randomised packets with random leading junk bytes and random acceptance
    for (int p = 0; p < 8; p++) begin
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        send_byte(8'($urandom), ($urandom_range(0, 9) != 0), 0);
      end
      rx   = 12'($urandom_range(0, 4095));
      ry   = 12'($urandom_range(0, 4095));
      rpen = 1'($urandom_range(0, 1));
      send5({7'h40, rpen}, {1'b0, rx[6:0]}, {1'b0, 2'($urandom), rx[11:7]},
            {1'b0, ry[6:0]}, {1'b0, 2'($urandom), ry[11:7]}, 0);
      idle_bits($urandom_range(0, 5));
      check_all("random");
      if ($urandom_range(0, 1) == 1) accept();
      if ($urandom_range(0, 3) == 0) clear_status();
    end
    check_all("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
